// File: rtl/snake_pkg.sv
// Shared types for the glyph-ROM arbiter: requester IDs, in-flight read tags
// and the default ROM address widths.
package snake_pkg;

  localparam int DEF_NUM_BITS   = 4;
  localparam int DEF_COUNT_BITS = 8;

  typedef enum logic {
    REQ_SCORE = 1'b0,
    REQ_TIME  = 1'b1
  } req_id_e;

  typedef struct packed {
    logic    valid;
    req_id_e owner;
  } tag_t;

  localparam tag_t TAG_EMPTY = '{valid: 1'b0, owner: REQ_SCORE};

  // Round-robin tie-break: the requester that did not win last time goes next.
  function automatic req_id_e rr_other(input req_id_e last_grant);
    return (last_grant == REQ_SCORE) ? REQ_TIME : REQ_SCORE;
  endfunction

endpackage

// File: rtl/tag_delay_line.sv
// Fixed-depth shift register of read tags; follows a shared ROM's pipeline so
// returned data can be routed back to whoever issued the read.
module tag_delay_line
  import snake_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  tag_t in_tag,
  output tag_t out_tag
);

  tag_t [DEPTH-1:0] stages;

  // NOTE: every stage is cleared on reset, unlike a data RAM: a stale valid bit
  // would surface as a phantom return. Non-blocking updates make the shift safe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stages <= '0;
    end else begin
      stages[0] <= in_tag;
      for (int i = 1; i < DEPTH; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign out_tag = stages[DEPTH-1];

endmodule

// File: rtl/number_rom_arbiter.sv
// Round-robin arbiter sharing the digit-glyph ROM between the score and time
// controllers, with a tag pipeline that routes each returned pixel to its owner.
module number_rom_arbiter
  import snake_pkg::*;
#(
  parameter int ROM_LATENCY   = 1,
  parameter int NUM_BITS      = DEF_NUM_BITS,
  parameter int COUNT_BITS    = DEF_COUNT_BITS,
  parameter int CONFLICT_BITS = 16
) (
  input  logic                     clock_25,
  input  logic                     reset,
  input  logic                     score_req,
  input  logic [NUM_BITS-1:0]      score_number,
  input  logic [COUNT_BITS-1:0]    score_count,
  input  logic                     time_req,
  input  logic [NUM_BITS-1:0]      time_number,
  input  logic [COUNT_BITS-1:0]    time_count,
  input  logic                     number_pixel,
  output logic [NUM_BITS-1:0]      selected_number,
  output logic [COUNT_BITS-1:0]    number_count,
  output logic                     score_gnt,
  output logic                     time_gnt,
  output logic                     score_pixel,
  output logic                     score_pixel_valid,
  output logic                     time_pixel,
  output logic                     time_pixel_valid,
  output logic [CONFLICT_BITS-1:0] conflict_count
);

  localparam int TAG_DEPTH = 1 + ROM_LATENCY;

  req_id_e                last_grant;
  logic                   grant_valid;
  req_id_e                grant_id;
  logic [NUM_BITS-1:0]    win_number;
  logic [COUNT_BITS-1:0]  win_count;
  tag_t                   issue_tag;
  tag_t                   tail_tag;

  // NOTE: every signal gets a default first so no path through this block
  // leaves a value unassigned, which would infer a latch.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = REQ_SCORE;
    if (score_req && time_req) begin
      grant_valid = 1'b1;
      grant_id    = rr_other(last_grant);
    end else if (score_req) begin
      grant_valid = 1'b1;
      grant_id    = REQ_SCORE;
    end else if (time_req) begin
      grant_valid = 1'b1;
      grant_id    = REQ_TIME;
    end
  end

  // Idle cycles drive 0/0 so an unused ROM address is always well defined.
  always_comb begin
    win_number = '0;
    win_count  = '0;
    if (grant_valid) begin
      if (grant_id == REQ_SCORE) begin
        win_number = score_number;
        win_count  = score_count;
      end else begin
        win_number = time_number;
        win_count  = time_count;
      end
    end
  end

  assign score_gnt = reset && grant_valid && (grant_id == REQ_SCORE);
  assign time_gnt  = reset && grant_valid && (grant_id == REQ_TIME);

  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      selected_number <= '0;
      number_count    <= '0;
    end else begin
      selected_number <= win_number;
      number_count    <= win_count;
    end
  end

  // Reset to time so that score wins the first conflict after reset.
  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      last_grant <= REQ_TIME;
    end else if (grant_valid) begin
      last_grant <= grant_id;
    end
  end

  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      conflict_count <= '0;
    end else if (score_req && time_req && (conflict_count != '1)) begin
      conflict_count <= conflict_count + CONFLICT_BITS'(1);
    end
  end

  assign issue_tag = '{valid: grant_valid, owner: grant_id};

  tag_delay_line #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_delay_line (
    .clk     (clock_25),
    .rst_n   (reset),
    .in_tag  (issue_tag),
    .out_tag (tail_tag)
  );

  // The tail tag lines up with the cycle in which number_pixel is valid.
  assign score_pixel_valid = tail_tag.valid && (tail_tag.owner == REQ_SCORE);
  assign time_pixel_valid  = tail_tag.valid && (tail_tag.owner == REQ_TIME);
  assign score_pixel       = score_pixel_valid && number_pixel;
  assign time_pixel        = time_pixel_valid && number_pixel;

endmodule
